fetch_stage: RTL

Instruction-fetch stage of the MIPS pipeline, directly upstream of the decoder. Holds the program counter and issues single-outstanding requests to the instruction memory. Owns the IF/ID pipeline register whose `f_o_instr`/`f_o_ce` drive the decoder's instruction and chip-enable inputs. Honours hazard-unit stalls and branch redirects (flush).

---
 rtl/fetch_stage.sv | 136 +++++++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - MIPS instruction-fetch stage: PC, single-outstanding imem requests, IF/ID register
// Optional FETCH_PERF_EN adds saturating fetch/flush counters.
module fetch_stage #(
  parameter int                  PC_WIDTH = 32,
  parameter int                  IWIDTH   = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                f_i_clk,
  input  logic                f_i_rst_n,
  output logic                f_o_imem_req,
  output logic [PC_WIDTH-1:0] f_o_imem_addr,
  input  logic                f_i_imem_ack,
  input  logic                f_i_imem_rvalid,
  input  logic [IWIDTH-1:0]   f_i_imem_rdata,
  input  logic                f_i_stall,
  input  logic                f_i_redirect,
  input  logic [PC_WIDTH-1:0] f_i_redirect_pc,
  output logic [IWIDTH-1:0]   f_o_instr,
  output logic                f_o_ce,
  output logic [PC_WIDTH-1:0] f_o_pc_plus4
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]         f_o_fetch_cnt,
  output logic [31:0]         f_o_flush_cnt
`endif
);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD, S_DROP} state_t;

  localparam logic [PC_WIDTH-1:0] PC_STEP    = PC_WIDTH'(4);
  localparam logic [PC_WIDTH-1:0] ALIGN_MASK = ~PC_WIDTH'(3);

  state_t                state_q, state_d;
  logic [PC_WIDTH-1:0]   pc_q, pc_d, pc_plus4_q, pc_plus4_d, pc_inc;
  logic [IWIDTH-1:0]     instr_q, instr_d, buf_q, buf_d, load_data;
  logic                  ce_q, ce_d, load;

  assign pc_inc = pc_q + PC_STEP;

  always_ff @(posedge f_i_clk or negedge f_i_rst_n) begin
    if (!f_i_rst_n) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC;
      pc_plus4_q <= '0;
      instr_q    <= '0;
      buf_q      <= '0;
      ce_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pc_plus4_q <= pc_plus4_d;
      instr_q    <= instr_d;
      buf_q      <= buf_d;
      ce_q       <= ce_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pc_plus4_d = pc_plus4_q;
    instr_d    = instr_q;
    buf_d      = buf_q;
    ce_d       = ce_q;
    load       = 1'b0;
    load_data  = f_i_imem_rdata;
    if (f_i_redirect) begin
      // Redirect wins over stall; any in-flight response becomes stale.
      pc_d    = f_i_redirect_pc & ALIGN_MASK;
      ce_d    = 1'b0;
      instr_d = '0;
      case (state_q)
        S_REQ:   state_d = f_i_imem_ack ? S_DROP : S_REQ;
        S_WAIT:  state_d = f_i_imem_rvalid ? S_REQ : S_DROP;
        S_DROP:  state_d = f_i_imem_rvalid ? S_REQ : S_DROP;
        default: state_d = S_REQ;
      endcase
    end else begin
      if (!f_i_stall) ce_d = 1'b0;
      case (state_q)
        S_IDLE: state_d = S_REQ;
        S_REQ:  if (f_i_imem_ack) state_d = S_WAIT;
        S_WAIT: begin
          if (f_i_imem_rvalid) begin
            if (!f_i_stall) begin
              load    = 1'b1;
              state_d = S_REQ;
            end else begin
              buf_d   = f_i_imem_rdata;
              state_d = S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (!f_i_stall) begin
            load      = 1'b1;
            load_data = buf_q;
            state_d   = S_REQ;
          end
        end
        S_DROP:  if (f_i_imem_rvalid) state_d = S_REQ;
        default: state_d = S_IDLE;
      endcase
      if (load) begin
        instr_d    = load_data;
        ce_d       = 1'b1;
        pc_plus4_d = pc_inc;
        pc_d       = pc_inc;
      end
    end
  end

  assign f_o_imem_req  = (state_q == S_REQ);
  assign f_o_imem_addr = pc_q;
  assign f_o_instr     = instr_q;
  assign f_o_ce        = ce_q;
  assign f_o_pc_plus4  = pc_plus4_q;

`ifdef FETCH_PERF_EN
  logic [31:0] fetch_cnt_q, flush_cnt_q;

  always_ff @(posedge f_i_clk or negedge f_i_rst_n) begin
    if (!f_i_rst_n) begin
      fetch_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (load && (fetch_cnt_q != 32'hFFFF_FFFF)) fetch_cnt_q <= fetch_cnt_q + 32'd1;
      if (f_i_redirect && (flush_cnt_q != 32'hFFFF_FFFF)) flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign f_o_fetch_cnt = fetch_cnt_q;
  assign f_o_flush_cnt = flush_cnt_q;
`endif

endmodule
